// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between I and D ports, D priority with I anti-starvation and a timeout watchdog
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          err,
  output logic          owner_d
);
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_e;
  state_e state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic owner_d_q, owner_d_d, m_req_q, m_req_d, m_we_q, m_we_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rd;
  logic gnt_d, gnt_i, done;
  // D wins unless I has already lost MAX_WAIT contended rounds in a row
  assign gnt_d = d_req && (!i_req || wait_cnt_q != 4'(MAX_WAIT));
  assign gnt_i = i_req && !gnt_d;
  assign done  = m_ack || tmo_cnt_q == 8'(TIMEOUT - 1);
  assign rd    = (m_ack && !m_we_q) ? m_rdata : '0;
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    owner_d_d  = owner_d_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: if (gnt_d || gnt_i) begin
        state_d    = MEM;
        m_req_d    = 1'b1;
        tmo_cnt_d  = '0;
        owner_d_d  = gnt_d;
        m_we_d     = gnt_d && d_we;
        m_addr_d   = gnt_d ? d_addr : i_addr;
        m_wdata_d  = gnt_d ? d_wdata : '0;
        wait_cnt_d = gnt_i ? '0 : i_req ? wait_cnt_q + 4'd1 : wait_cnt_q;
      end
      MEM: if (done) begin
        state_d   = RESP;
        m_req_d   = 1'b0;
        i_ack_d   = !owner_d_q;
        d_ack_d   = owner_d_q;
        err_d     = !m_ack;
        i_rdata_d = owner_d_q ? i_rdata_q : rd;
        d_rdata_d = owner_d_q ? rd : d_rdata_q;
      end else
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      default: begin
        state_d   = IDLE;
        owner_d_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      owner_d_q  <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      owner_d_q  <= owner_d_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
    end
  assign i_rdata = i_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_ack   = d_ack_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign err     = err_q;
  assign owner_d = owner_d_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic i_ack, d_ack, m_req, m_we, err, owner_d;
  logic ed;
  logic [31:0] dat, last_d;
  int n_tests = 0, n_fail = 0, cnt;
  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(3), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .err(err), .owner_d(owner_d)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst m_req", m_req, 0);
    check("rst acks", {i_ack, d_ack, err, owner_d, m_we}, 0);
    check("rst rdata", i_rdata | d_rdata | m_addr | m_wdata, 0);
    reset = 1'b1;
    tick;
    // I-only read, two-cycle memory
    i_req = 1'b1; i_addr = 32'h0040_0000;
    tick;
    check("t1 m_req c1", m_req, 1);
    check("t1 m_we", m_we, 0);
    check("t1 m_addr", m_addr, 32'h0040_0000);
    check("t1 owner", owner_d, 0);
    tick;
    check("t1 m_req c2", m_req, 1);
    check("t1 no ack c2", i_ack, 0);
    m_ack = 1'b1; m_rdata = 32'h8C08_0004;
    tick;
    m_ack = 1'b0; i_req = 1'b0;
    check("t1 i_ack", i_ack, 1);
    check("t1 i_rdata", i_rdata, 32'h8C08_0004);
    check("t1 m_req c3", m_req, 0);
    check("t1 d_ack", d_ack, 0);
    tick;
    check("t1 i_ack c4", i_ack, 0);
    // D write, zero-wait memory
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
    tick;
    check("t2 m_req", m_req, 1);
    check("t2 m_we", m_we, 1);
    check("t2 m_addr", m_addr, 32'h1001_0000);
    check("t2 m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("t2 owner c1", owner_d, 1);
    m_ack = 1'b1; m_rdata = 32'h7777_7777;
    tick;
    m_ack = 1'b0; d_req = 1'b0;
    check("t2 d_ack", d_ack, 1);
    check("t2 d_rdata", d_rdata, 0);
    check("t2 owner c2", owner_d, 1);
    check("t2 i_ack", i_ack, 0);
    tick;
    check("t2 owner c3", owner_d, 0);
    // Both continuously requesting, zero-wait memory
    last_d = 32'h0;
    i_req = 1'b1; i_addr = 32'h0040_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0040; m_ack = 1'b1;
    for (int n = 0; n < 8; n++) begin
      ed = (n % 4) != 3;
      dat = 32'hC0DE_0000 + 32'(n);
      tick;
      check("t3 m_req", m_req, 1);
      check("t3 owner", owner_d, ed);
      check("t3 m_addr", m_addr, ed ? 32'h1001_0040 : 32'h0040_0100);
      m_rdata = dat;
      tick;
      check("t3 d_ack", d_ack, ed);
      check("t3 i_ack", i_ack, !ed);
      check("t3 overlap", i_ack & d_ack, 0);
      if (ed) begin
        check("t3 d_rdata", d_rdata, dat);
        last_d = dat;
      end else begin
        check("t3 i_rdata", i_rdata, dat);
        check("t3 d_hold", d_rdata, last_d);
      end
      tick;
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    tick;
    // Memory never acks: watchdog abort
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0080;
    cnt = 0;
    for (int k = 0; k < 100 && !d_ack; k++) begin
      tick;
      if (m_req) cnt++;
    end
    check("t4 m_req cycles", cnt, 64);
    check("t4 d_ack", d_ack, 1);
    check("t4 err", err, 1);
    check("t4 d_rdata", d_rdata, 0);
    d_req = 1'b0;
    tick;
    check("t4 err drop", err, 0);
    d_req = 1'b1; d_addr = 32'h1001_0084; m_ack = 1'b1; m_rdata = 32'h1234_5678;
    tick;
    tick;
    check("t4 next d_ack", d_ack, 1);
    check("t4 next err", err, 0);
    check("t4 next d_rdata", d_rdata, 32'h1234_5678);
    d_req = 1'b0; m_ack = 1'b0;
    tick;
    // Asynchronous reset mid-transaction
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0100; d_wdata = 32'h0BAD_F00D;
    tick;
    check("t5 m_req pre", m_req, 1);
    #1 reset = 1'b0;
    #1;
    check("t5 m_req async", m_req, 0);
    check("t5 owner async", owner_d, 0);
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0040_0200;
    tick;
    check("t5 no ack", {i_ack, d_ack, m_req}, 0);
    #2 reset = 1'b1;
    tick;
    check("t5 regrant m_req", m_req, 1);
    check("t5 regrant owner", owner_d, 0);
    check("t5 regrant addr", m_addr, 32'h0040_0200);
    m_ack = 1'b1; m_rdata = 32'h2402_0005;
    tick;
    check("t5 i_ack", i_ack, 1);
    check("t5 i_rdata", i_rdata, 32'h2402_0005);
    check("t5 d_ack", d_ack, 0);
    i_req = 1'b0; m_ack = 1'b0;
    tick;
    // Stray m_ack in IDLE, then m_ack coinciding with timeout
    m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick;
    m_ack = 1'b0;
    tick;
    check("t6 idle acks", {i_ack, d_ack, m_req, err}, 0);
    check("t6 i_rdata hold", i_rdata, 32'h2402_0005);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0200;
    tick;
    repeat (63) tick;
    check("t6 m_req c64", m_req, 1);
    m_ack = 1'b1; m_rdata = 32'h5A5A_5A5A;
    tick;
    m_ack = 1'b0; d_req = 1'b0;
    check("t6 d_ack", d_ack, 1);
    check("t6 err", err, 0);
    check("t6 d_rdata", d_rdata, 32'h5A5A_5A5A);
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
